// File: rtl/cbus_sram_responder_if.sv
//------------------------------------------------------------------------------
// Module   : cbus_sram_responder_if
// Purpose  : Cache-bus request/response bundle between an initiator (cache or
//            uncached master) and a memory-side responder.
// Signals  : creq_*  - request from initiator (valid, is_write, size, addr,
//                      strobe, data, len = beats-1)
//            cresp_* - response from responder (ready = one beat transferred,
//                      last = final beat, data = read data)
// Modports : master (initiator side), slave (responder side)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cbus_sram_responder_if;
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [31:0] creq_addr;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic [3:0]  creq_len;

  logic        cresp_ready;
  logic        cresp_last;
  logic [31:0] cresp_data;

  modport master (
    output creq_valid, creq_is_write, creq_size, creq_addr,
           creq_strobe, creq_data, creq_len,
    input  cresp_ready, cresp_last, cresp_data
  );

  modport slave (
    input  creq_valid, creq_is_write, creq_size, creq_addr,
           creq_strobe, creq_data, creq_len,
    output cresp_ready, cresp_last, cresp_data
  );
endinterface

`default_nettype wire

// File: rtl/cbus_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : cbus_sram_responder
// Purpose  : Serves one cache-bus burst at a time from a single-port
//            synchronous SRAM with 1-cycle read latency.
// Ports    : clk, resetn   - clock, async active-low reset
//            cbus (slave)  - cache-bus request/response bundle
//            mem_en        - SRAM access enable
//            mem_addr      - SRAM word address
//            mem_wen       - SRAM byte write enables
//            mem_wdata     - SRAM write data
//            mem_rdata     - SRAM read data (one cycle after a read)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cbus_sram_responder #(
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int ACCESS_LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  cbus_sram_responder_if.slave      cbus,
  output logic                      mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_wen,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  localparam logic [MEM_ADDR_WIDTH-1:0] C_ADDR_ONE = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_is_write;
  logic [3:0]                r_len;
  logic [3:0]                r_beat;
  logic [3:0]                r_wait;
  logic [MEM_ADDR_WIDTH-1:0] r_base;

  logic                      w_last;
  logic [MEM_ADDR_WIDTH-1:0] w_beat_addr;
  logic [MEM_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_ready;
  logic                      w_resp_last;
  logic [31:0]               w_resp_data;

  // Size and the byte offset / aliased upper address bits play no part in
  // word addressing; sub-word writes are expressed through the strobe.
  logic w_unused_bits;
  assign w_unused_bits = ^{cbus.creq_size, cbus.creq_addr[31:MEM_ADDR_WIDTH+2],
                           cbus.creq_addr[1:0]};

  assign w_last      = (r_beat == r_len);
  // Additions wrap naturally modulo 2^MEM_ADDR_WIDTH.
  assign w_beat_addr = r_base + MEM_ADDR_WIDTH'(r_beat);
  assign w_next_addr = w_beat_addr + C_ADDR_ONE;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst context: latched in IDLE, then only the counters move.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_write <= 1'b0;
      r_len      <= 4'd0;
      r_beat     <= 4'd0;
      r_wait     <= 4'd0;
      r_base     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cbus.creq_valid) begin
            r_is_write <= cbus.creq_is_write;
            r_len      <= cbus.creq_len;
            r_base     <= cbus.creq_addr[MEM_ADDR_WIDTH+1:2];
            r_wait     <= 4'(ACCESS_LATENCY);
            r_beat     <= 4'd0;
          end
        end
        S_WAIT: begin
          if (cbus.creq_valid && (r_wait != 4'd0)) begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_BURST: begin
          // Saturates at len: the last beat leaves the counter untouched.
          if (cbus.creq_valid && !w_last) begin
            r_beat <= r_beat + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and all outputs. Everything is combinational from state so
  // that an asynchronous reset clears the outputs in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_resp_last = 1'b0;
    w_resp_data = 32'd0;
    mem_en      = 1'b0;
    mem_addr    = '0;
    mem_wen     = 4'd0;
    mem_wdata   = 32'd0;

    case (r_state)
      S_IDLE: begin
        if (cbus.creq_valid) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!cbus.creq_valid) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait == 4'd0) begin
          w_state_nxt = S_BURST;
          // Prefetch beat 0 so its data is on mem_rdata in the first
          // BURST cycle.
          if (!r_is_write) begin
            mem_en   = 1'b1;
            mem_addr = r_base;
          end
        end
      end

      S_BURST: begin
        if (!cbus.creq_valid) begin
          // Abort: no ready and no SRAM write in this cycle.
          w_state_nxt = S_IDLE;
        end else begin
          w_ready     = 1'b1;
          w_resp_last = w_last;
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end
          if (r_is_write) begin
            mem_en    = 1'b1;
            mem_addr  = w_beat_addr;
            mem_wen   = cbus.creq_strobe;
            mem_wdata = cbus.creq_data;
          end else begin
            w_resp_data = mem_rdata;
            // Read-ahead of the following beat keeps beats back-to-back.
            if (!w_last) begin
              mem_en   = 1'b1;
              mem_addr = w_next_addr;
            end
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cbus.cresp_ready = w_ready;
  assign cbus.cresp_last  = w_resp_last;
  assign cbus.cresp_data  = w_resp_data;

endmodule

`default_nettype wire

// File: tb/tb_cbus_sram_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_cbus_sram_responder
// Purpose  : Self-checking bench for cbus_sram_responder. Two instances:
//            dut0 (MEM_ADDR_WIDTH=14, ACCESS_LATENCY=0) and
//            dut1 (MEM_ADDR_WIDTH=4,  ACCESS_LATENCY=3), each with its own
//            SRAM model. Bursts are described in a table of records.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cbus_sram_responder;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Shared request fields, per-instance valid
  logic        v0, v1;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [3:0]  d_len;
  logic [3:0]  d_strb;
  logic [31:0] d_data;

  cbus_sram_responder_if if0 ();
  cbus_sram_responder_if if1 ();

  assign if0.creq_valid    = v0;
  assign if0.creq_is_write = d_wr;
  assign if0.creq_size     = 3'b010;
  assign if0.creq_addr     = d_addr;
  assign if0.creq_strobe   = d_strb;
  assign if0.creq_data     = d_data;
  assign if0.creq_len      = d_len;
  assign if1.creq_valid    = v1;
  assign if1.creq_is_write = d_wr;
  assign if1.creq_size     = 3'b010;
  assign if1.creq_addr     = d_addr;
  assign if1.creq_strobe   = d_strb;
  assign if1.creq_data     = d_data;
  assign if1.creq_len      = d_len;

  logic        m0_en, m1_en;
  logic [13:0] m0_addr;
  logic [3:0]  m1_addr;
  logic [3:0]  m0_wen, m1_wen;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;

  cbus_sram_responder #(.MEM_ADDR_WIDTH(14), .ACCESS_LATENCY(0)) dut0 (
    .clk(clk), .resetn(resetn), .cbus(if0),
    .mem_en(m0_en), .mem_addr(m0_addr), .mem_wen(m0_wen),
    .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
  );

  cbus_sram_responder #(.MEM_ADDR_WIDTH(4), .ACCESS_LATENCY(3)) dut1 (
    .clk(clk), .resetn(resetn), .cbus(if1),
    .mem_en(m1_en), .mem_addr(m1_addr), .mem_wen(m1_wen),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
  );

  // SRAM models: synchronous, 1-cycle read latency, byte write enables
  logic [31:0] mem0 [0:16383];
  logic [31:0] mem1 [0:15];

  always @(posedge clk) begin
    if (m0_en) begin
      if (m0_wen == 4'd0) m0_rdata <= mem0[m0_addr];
      for (int b = 0; b < 4; b++)
        if (m0_wen[b]) mem0[m0_addr][8*b +: 8] <= m0_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (m1_en) begin
      if (m1_wen == 4'd0) m1_rdata <= mem1[m1_addr];
      for (int b = 0; b < 4; b++)
        if (m1_wen[b]) mem1[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
    end
  end

  // Observed response of the selected instance
  logic        cur_sel;
  logic        o_ready, o_last;
  logic [31:0] o_data;
  assign o_ready = cur_sel ? if1.cresp_ready : if0.cresp_ready;
  assign o_last  = cur_sel ? if1.cresp_last  : if0.cresp_last;
  assign o_data  = cur_sel ? if1.cresp_data  : if0.cresp_data;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;         // 0: dut0, 1: dut1
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  len;
    int          abort_beat;  // -1: no abort
    bit          chain;       // keep valid high into the next record
    int          tail;        // idle cycles checked after the last beat
    logic [31:0] wdata [16];
    logic [3:0]  wstrb [16];
    logic [31:0] exp   [16];
  } vec_t;

  localparam int NVEC = 9;
  vec_t vec [NVEC];

  // Entered and left just after a rising edge. Beat b is expected at
  // cycle 2+latency+b, counting the cycle valid is raised as 0.
  task automatic run_vec(input int i);
    int lat, kmax, beat, nb;
    bit exp_r;
    vec_t v;
    v       = vec[i];
    lat     = v.sel ? 3 : 0;
    kmax    = 2 + lat + int'(v.len) + (v.chain ? 0 : v.tail);
    cur_sel = v.sel;
    d_wr    = v.wr;
    d_addr  = v.addr;
    d_len   = v.len;
    d_data  = v.wdata[0];
    d_strb  = v.wstrb[0];
    if (v.sel) v1 = 1'b1; else v0 = 1'b1;
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      beat  = k - 2 - lat;
      exp_r = (beat >= 0) && (beat <= int'(v.len)) &&
              !(v.abort_beat >= 0 && beat >= v.abort_beat);
      check($sformatf("v%0d c%0d ready/last", i, k), {30'd0, o_ready, o_last},
            {30'd0, exp_r, exp_r && (beat == int'(v.len))});
      if (exp_r && !v.wr)
        check($sformatf("v%0d beat%0d data", i, beat), o_data, v.exp[beat]);
      @(posedge clk);
      #1;
      nb = k + 1 - 2 - lat;
      if ((nb > int'(v.len) && !v.chain) || (v.abort_beat >= 0 && nb >= v.abort_beat)) begin
        if (v.sel) v1 = 1'b0; else v0 = 1'b0;
      end
      if (nb >= 0 && nb < 16) begin
        d_data = v.wdata[nb];
        d_strb = v.wstrb[nb];
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    v0      = 1'b0;
    v1      = 1'b0;
    cur_sel = 1'b0;
    d_wr    = 1'b0;
    d_addr  = 32'd0;
    d_len   = 4'd0;
    d_strb  = 4'd0;
    d_data  = 32'd0;

    for (int i = 0; i < NVEC; i++) begin
      vec[i].sel = 1'b0; vec[i].wr = 1'b0; vec[i].addr = 32'd0; vec[i].len = 4'd0;
      vec[i].abort_beat = -1; vec[i].chain = 1'b0; vec[i].tail = 2;
      for (int k = 0; k < 16; k++) begin
        vec[i].wdata[k] = 32'd0; vec[i].wstrb[k] = 4'hF; vec[i].exp[k] = 32'd0;
      end
    end
    // 0: 16-beat read of words 0x40.. holding 0..15
    vec[0].addr = 32'h100; vec[0].len = 4'd15;
    for (int k = 0; k < 16; k++) vec[0].exp[k] = 32'(k);
    // 1: 4-beat write at 0x40, beat 2 writes only the low half
    vec[1].wr = 1'b1; vec[1].addr = 32'h40; vec[1].len = 4'd3;
    for (int k = 0; k < 4; k++) vec[1].wdata[k] = 32'hA0 + 32'(k);
    vec[1].wstrb[2] = 4'h3;
    // 2: read back of vector 1
    vec[2].addr = 32'h40; vec[2].len = 4'd3;
    vec[2].exp[0] = 32'h0000_00A0; vec[2].exp[1] = 32'h0000_00A1;
    vec[2].exp[2] = 32'hFFFF_00A2; vec[2].exp[3] = 32'h0000_00A3;
    // 3: single beat on the latency-3 instance, long quiet tail
    vec[3].sel = 1'b1; vec[3].addr = 32'h14; vec[3].len = 4'd0; vec[3].tail = 10;
    vec[3].exp[0] = 32'h0000_55AA;
    // 4: wrap 14,15,0,1 on the 16-word instance, upper address bits aliased
    vec[4].sel = 1'b1; vec[4].addr = 32'h1038; vec[4].len = 4'd3;
    vec[4].exp[0] = 32'hB14; vec[4].exp[1] = 32'hB15;
    vec[4].exp[2] = 32'hB00; vec[4].exp[3] = 32'hB01;
    // 5: 16-beat write at 0 aborted at beat 3
    vec[5].wr = 1'b1; vec[5].addr = 32'h0; vec[5].len = 4'd15; vec[5].abort_beat = 3;
    for (int k = 0; k < 16; k++) vec[5].wdata[k] = 32'h1000 + 32'(k);
    // 6: read back: only words 0..2 changed
    vec[6].addr = 32'h0; vec[6].len = 4'd15;
    for (int k = 0; k < 16; k++)
      vec[6].exp[k] = (k < 3) ? 32'h1000 + 32'(k) : 32'hDEAD_0000 + 32'(k);
    // 7,8: back-to-back 16-beat reads
    vec[7] = vec[0]; vec[7].chain = 1'b1;
    vec[8] = vec[0];

    for (int k = 0; k < 16; k++) begin
      mem0[32'h40 + k] <= 32'(k);
      mem0[k]          <= 32'hDEAD_0000 + 32'(k);
    end
    for (int k = 0; k < 4; k++) mem0[32'h10 + k] <= 32'hFFFF_FFFF;
    mem1[5]  <= 32'h55AA;
    mem1[14] <= 32'hB14;
    mem1[15] <= 32'hB15;
    mem1[0]  <= 32'hB00;
    mem1[1]  <= 32'hB01;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset cresp", {if0.cresp_ready, if0.cresp_last, if0.cresp_data[29:0]}, 32'd0);
    check("reset mem_en/wen/addr", {13'd0, m0_en, m0_wen, m0_addr}, 32'd0);
    check("reset mem_wdata", m0_wdata, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset in the middle of a read burst
    cur_sel = 1'b0;
    d_wr    = 1'b0;
    d_addr  = 32'h100;
    d_len   = 4'd15;
    v0      = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid-burst ready before reset", {31'd0, if0.cresp_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    check("reset cresp same cycle", {if0.cresp_ready, if0.cresp_last, if0.cresp_data[29:0]}, 32'd0);
    check("reset mem_en same cycle", {31'd0, m0_en}, 32'd0);
    v0 = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
